// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO issue-side controller.
//   - 3-bit opcode constants presented by the execute stage
//   - FSM state encoding
//   - helper that classifies an opcode as a HI/LO op (6 and 7 behave as NONE)
package hilo_pkg;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_DIV  = 3'd1;
    localparam logic [2:0] OP_MTHI = 3'd2;
    localparam logic [2:0] OP_MTLO = 3'd3;
    localparam logic [2:0] OP_MFHI = 3'd4;
    localparam logic [2:0] OP_MFLO = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam int TIMEOUT_DEF = 40;
    localparam int CNT_W_DEF   = 6;

    // True for every opcode this block acts on; reserved codes fall out as NONE.
    function automatic logic is_hilo_op(input logic [2:0] op);
        return (op >= OP_DIV) && (op <= OP_MFLO);
    endfunction

endpackage

// File: rtl/hilo_timeout_cnt.sv
// hilo_timeout_cnt: watchdog counter for an in-flight division.
//   clk_i   clock
//   rst_ni  synchronous active-low reset
//   clr_i   load zero (has priority over en_i)
//   en_i    increment by one
//   cnt_o   current count
//   tc_o    count has reached TIMEOUT-1
module hilo_timeout_cnt #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: issue-side controller for the HI/LO special registers.
// Executes MTHI/MTLO/MFHI/MFLO directly, launches the external iterative
// divider for DIV, commits its remainder/quotient into HI/LO, and stalls the
// execute stage while a division is in flight. A watchdog aborts a division
// that never reports div_end and pulses a reset into the divider.
//   clk_i, rst_ni          clock, synchronous active-low reset
//   op_valid_i, op_i       op from execute (held by execute while stall_o=1)
//   rs_val_i, rt_val_i     dividend / MT* data, divisor
//   stall_o, rd_data_o     retry request, MFHI/MFLO result (combinational)
//   div_start_o            one-cycle launch pulse
//   dividend_o, divisor_o  registered divider operands
//   div_rst_o              active-high divider reset
//   div_end_i, div_hi_i, div_lo_i  divider completion, remainder, quotient
//   hi_o, lo_o             architectural HI/LO
//   busy_o                 division in flight
//   dz_err_o, to_err_o     divide-by-zero / timeout pulses
module hilo_ctrl
    import hilo_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF   // 2**CNT_W must exceed TIMEOUT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        op_valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] rs_val_i,
    input  logic [31:0] rt_val_i,
    output logic        stall_o,
    output logic [31:0] rd_data_o,
    output logic        div_start_o,
    output logic [31:0] dividend_o,
    output logic [31:0] divisor_o,
    output logic        div_rst_o,
    input  logic        div_end_i,
    input  logic [31:0] div_hi_i,
    input  logic [31:0] div_lo_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy_o,
    output logic        dz_err_o,
    output logic        to_err_o
);

    state_e      state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] dividend_q, dividend_d, divisor_q, divisor_d;
    logic        div_start_q, div_start_d;
    logic        dz_err_q, dz_err_d;
    logic        to_err_q, to_err_d;

    logic             cnt_clr, cnt_en, cnt_tc;
    logic [CNT_W-1:0] cnt_unused;

    hilo_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_tmo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .cnt_o  (cnt_unused),
        .tc_o   (cnt_tc)
    );

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        div_start_d = 1'b0;
        dz_err_d    = 1'b0;
        to_err_d    = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (op_valid_i) begin
                    case (op_i)
                        OP_DIV: begin
                            if (rt_val_i != '0) begin
                                dividend_d  = rs_val_i;
                                divisor_d   = rt_val_i;
                                div_start_d = 1'b1;
                                cnt_clr     = 1'b1;
                                state_d     = WAIT;
                            end else begin
                                dz_err_d = 1'b1;
                            end
                        end
                        OP_MTHI: hi_d = rs_val_i;
                        OP_MTLO: lo_d = rs_val_i;
                        default: ;
                    endcase
                end
            end
            WAIT: begin
                // A completion in the terminal-count cycle still commits.
                if (div_end_i) begin
                    hi_d    = div_hi_i;
                    lo_d    = div_lo_i;
                    state_d = IDLE;
                end else if (cnt_tc) begin
                    to_err_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            hi_q        <= '0;
            lo_q        <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            div_start_q <= 1'b0;
            dz_err_q    <= 1'b0;
            to_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            div_start_q <= div_start_d;
            dz_err_q    <= dz_err_d;
            to_err_q    <= to_err_d;
        end
    end

    // MF* reads see the committed HI/LO; an op held in the div_end cycle
    // stays stalled and reads the new value one cycle later.
    always_comb begin
        rd_data_o = '0;
        case (op_i)
            OP_MFHI: rd_data_o = hi_q;
            OP_MFLO: rd_data_o = lo_q;
            default: ;
        endcase
    end

    assign busy_o      = (state_q == WAIT);
    assign stall_o     = op_valid_i & is_hilo_op(op_i) & busy_o;
    assign div_start_o = div_start_q;
    assign dividend_o  = dividend_q;
    assign divisor_o   = divisor_q;
    // Divider is held in reset with the block and kicked for one cycle on timeout.
    assign div_rst_o   = ~rst_ni | to_err_q;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
    assign dz_err_o    = dz_err_q;
    assign to_err_o    = to_err_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
module tb_hilo_ctrl;
    import hilo_pkg::*;

    localparam int DIV_LAT = 33;

    logic        clk, rst_n;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        stall, div_start, div_rst, div_end, busy, dz_err, to_err;
    logic [31:0] rd_data, dividend, divisor, div_hi, div_lo, hi, lo;

    int n_tests = 0;
    int n_fail  = 0;
    bit div_en  = 1'b1;
    int mcnt    = 0;

    hilo_ctrl #(.TIMEOUT(40), .CNT_W(6)) dut (
        .clk_i(clk), .rst_ni(rst_n), .op_valid_i(op_valid), .op_i(op),
        .rs_val_i(rs_val), .rt_val_i(rt_val), .stall_o(stall), .rd_data_o(rd_data),
        .div_start_o(div_start), .dividend_o(dividend), .divisor_o(divisor),
        .div_rst_o(div_rst), .div_end_i(div_end), .div_hi_i(div_hi), .div_lo_i(div_lo),
        .hi_o(hi), .lo_o(lo), .busy_o(busy), .dz_err_o(dz_err), .to_err_o(to_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Divider model: signed divide, div_end DIV_LAT cycles after the start pulse.
    initial begin
        div_end = 1'b0;
        div_hi  = '0;
        div_lo  = '0;
    end
    always @(posedge clk) begin
        div_end <= 1'b0;
        if (div_start && divisor != 0) begin
            mcnt   <= DIV_LAT - 1;
            div_lo <= $signed(dividend) / $signed(divisor);
            div_hi <= $signed(dividend) % $signed(divisor);
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) div_end <= div_en;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op_valid = v;
        op       = o;
        rs_val   = a;
        rt_val   = b;
    endtask

    // Launch a DIV from IDLE and follow it to completion.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int bc, starts;
        @(negedge clk);
        drive(1'b1, OP_DIV, a, b);
        #1 chk("div_issue_stall", stall, 0);
        @(negedge clk);
        chk("div_busy", busy, 1);
        chk("div_start_pulse", div_start, 1);
        chk("div_dividend", dividend, a);
        chk("div_divisor", divisor, b);
        drive(1'b0, OP_NONE, '0, '0);
        bc = 1;
        starts = 1;
        for (int i = 0; i < 80 && busy; i++) begin
            @(negedge clk);
            if (busy) bc++;
            starts += int'(div_start);
        end
        chk("div_done", busy, 0);
        chk("div_busy_cycles", bc, DIV_LAT + 1);
        chk("div_start_count", starts, 1);
        chk("div_hi", hi, exp_hi);
        chk("div_lo", lo, exp_lo);
    endtask

    typedef struct {
        logic        vld;
        logic [2:0]  op;
        logic [31:0] rs, rt;
        logic        exp_stall;
        logic [31:0] exp_rd, exp_hi, exp_lo;
        logic        exp_dz;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int first, busy39;
        bit prev_end, saw_end;

        vecs[0]  = '{1'b1, OP_MTHI, 32'hAAAA, 32'h0,  1'b0, 32'h0,    32'hAAAA, 32'h0,    1'b0};
        vecs[1]  = '{1'b1, OP_MTLO, 32'h5555, 32'h0,  1'b0, 32'h0,    32'hAAAA, 32'h5555, 1'b0};
        vecs[2]  = '{1'b1, OP_MFHI, 32'h0,    32'h0,  1'b0, 32'hAAAA, 32'hAAAA, 32'h5555, 1'b0};
        vecs[3]  = '{1'b1, OP_MFLO, 32'h0,    32'h0,  1'b0, 32'h5555, 32'hAAAA, 32'h5555, 1'b0};
        vecs[4]  = '{1'b1, OP_NONE, 32'd123,  32'h0,  1'b0, 32'h0,    32'hAAAA, 32'h5555, 1'b0};
        vecs[5]  = '{1'b1, 3'd6,    32'd77,   32'h0,  1'b0, 32'h0,    32'hAAAA, 32'h5555, 1'b0};
        vecs[6]  = '{1'b1, 3'd7,    32'd99,   32'd3,  1'b0, 32'h0,    32'hAAAA, 32'h5555, 1'b0};
        vecs[7]  = '{1'b1, OP_DIV,  32'd5,    32'd0,  1'b0, 32'h0,    32'hAAAA, 32'h5555, 1'b1};
        vecs[8]  = '{1'b0, OP_MTHI, 32'hDEAD, 32'h0,  1'b0, 32'h0,    32'hAAAA, 32'h5555, 1'b0};
        vecs[9]  = '{1'b0, OP_DIV,  32'd8,    32'd2,  1'b0, 32'h0,    32'hAAAA, 32'h5555, 1'b0};
        vecs[10] = '{1'b1, OP_MFHI, 32'h0,    32'h0,  1'b0, 32'hAAAA, 32'hAAAA, 32'h5555, 1'b0};

        // Reset
        drive(1'b0, OP_NONE, '0, '0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_dividend", dividend, 0);
        chk("rst_divisor", divisor, 0);
        chk("rst_div_start", div_start, 0);
        chk("rst_dz", dz_err, 0);
        chk("rst_to", to_err, 0);
        chk("rst_div_rst", div_rst, 1);
        rst_n = 1'b1;
        #1 chk("rst_div_rst_rel", div_rst, 0);

        // Single-cycle ops from IDLE
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].vld, vecs[i].op, vecs[i].rs, vecs[i].rt);
            #1;
            chk($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
            chk($sformatf("vec%0d_rd", i), rd_data, vecs[i].exp_rd);
            @(negedge clk);
            chk($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
            chk($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
            chk($sformatf("vec%0d_dz", i), dz_err, vecs[i].exp_dz);
            chk($sformatf("vec%0d_start", i), div_start, 0);
            chk($sformatf("vec%0d_busy", i), busy, 0);
            drive(1'b0, OP_NONE, '0, '0);
        end

        // Divisions through the divider model
        run_div(32'd100, 32'd7, 32'd2, 32'd14);
        run_div(32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);

        // MFLO held behind a DIV: released the cycle after div_end
        @(negedge clk);
        drive(1'b1, OP_DIV, 32'd100, 32'd7);
        @(negedge clk);
        drive(1'b0, OP_NONE, '0, '0);
        @(negedge clk);
        drive(1'b1, OP_MFLO, '0, '0);
        #1 chk("mflo_stall_first", stall, 1);
        prev_end = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (!stall) break;
            prev_end = div_end;
        end
        chk("mflo_released", stall, 0);
        chk("mflo_after_div_end", prev_end, 1);
        chk("mflo_rd", rd_data, 32'd14);
        drive(1'b0, OP_NONE, '0, '0);

        // Timeout: divider never answers
        div_en = 1'b0;
        @(negedge clk);
        drive(1'b1, OP_DIV, 32'd9, 32'd3);
        @(negedge clk);
        drive(1'b0, OP_NONE, '0, '0);
        first  = -1;
        busy39 = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 39) busy39 = int'(busy);
            if (to_err) begin
                first = k;
                break;
            end
        end
        chk("tmo_cycle", first, 40);
        chk("tmo_busy_before", busy39, 1);
        chk("tmo_div_rst", div_rst, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_hi", hi, 32'd2);
        chk("tmo_lo", lo, 32'd14);
        @(negedge clk);
        chk("tmo_to_pulse", to_err, 0);
        chk("tmo_div_rst_pulse", div_rst, 0);
        drive(1'b1, OP_MTHI, 32'h1234, '0);
        @(negedge clk);
        chk("tmo_mthi", hi, 32'h1234);
        drive(1'b0, OP_NONE, '0, '0);
        div_en = 1'b1;

        // Reset in the middle of a division
        @(negedge clk);
        drive(1'b1, OP_DIV, 32'd100, 32'd7);
        @(negedge clk);
        drive(1'b0, OP_NONE, '0, '0);
        repeat (10) @(negedge clk);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1 chk("mid_div_rst", div_rst, 1);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_busy_after", busy, 0);
        chk("mid_hi", hi, 0);
        chk("mid_lo", lo, 0);
        chk("mid_dividend", dividend, 0);
        saw_end = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_end) saw_end = 1'b1;
        end
        chk("mid_late_end_seen", saw_end, 1);
        chk("mid_late_hi", hi, 0);
        chk("mid_late_lo", lo, 0);
        chk("mid_late_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hilo_ctrl.md
Name: hilo_ctrl

Overview:
- Issue-side controller for the HI/LO special registers of the MIPS core.
- Accepts DIV, MTHI, MTLO, MFHI and MFLO ops from the execute stage.
- Launches and monitors the iterative divider, commits its hi/lo results, and stalls the pipeline while a division is in flight.
- Sits directly upstream of the divider: drives its start/operands and consumes div_end, hi and lo.

Parameters:
- TIMEOUT, 40, max cycles to wait for div_end after div_start before aborting.
- CNT_W, 6, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- op_valid  in  1  an op is presented this cycle.
- op  in  3  opcode, encoded per shared package.
- rs_val  in  32  dividend for DIV; write data for MTHI/MTLO.
- rt_val  in  32  divisor for DIV.
- stall  out  1  execute stage must hold the op and retry.
- rd_data  out  32  MFHI/MFLO result, valid when op_valid & ~stall.
- div_start  out  1  one-cycle launch pulse to the divider.
- dividend  out  32  registered operand to the divider.
- divisor  out  32  registered operand to the divider.
- div_rst  out  1  active-high divider reset.
- div_end  in  1  divider completion pulse.
- div_hi  in  32  divider remainder.
- div_lo  in  32  divider quotient.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.
- busy  out  1  division in flight.
- dz_err  out  1  one-cycle pulse: DIV with zero divisor.
- to_err  out  1  one-cycle pulse: divider timeout.

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE; hi=lo=0; dividend=divisor=0; counter=0.
  - div_start=dz_err=to_err=0.
  - div_rst=1 combinationally while rst=0.
- FSM states: IDLE, WAIT. busy = (state==WAIT).
- IDLE, op_valid & op==DIV & rt_val!=0:
  - Next edge: dividend<=rs_val, divisor<=rt_val, div_start<=1 for exactly one cycle, counter<=0, state<=WAIT.
- IDLE, op_valid & op==DIV & rt_val==0:
  - Divider is not started; hi/lo unchanged.
  - dz_err pulses for one cycle; state stays IDLE.
- IDLE, MTHI/MTLO: hi (resp. lo) <= rs_val at the next edge.
- IDLE, MFHI/MFLO: rd_data = hi/lo combinationally in the same cycle; stall=0.
- rd_data = 0 when op is not MFHI/MFLO.
- stall = op_valid & op!=NONE & state==WAIT.
  - Every HI/LO op stalls while busy, including a second DIV, an MT* and an MF*.
- WAIT, div_end=1: hi<=div_hi, lo<=div_lo, state<=IDLE.
  - An op stalled in that same cycle stays stalled.
  - It proceeds next cycle and observes the new hi/lo.
- WAIT, no div_end: counter increments each cycle.
- WAIT, counter reaches TIMEOUT-1 without div_end:
  - state<=IDLE; hi/lo unchanged.
  - to_err pulses one cycle; div_rst pulses one cycle.
- div_end while IDLE: ignored; hi/lo unchanged.
- Reset mid-WAIT: abort immediately; all registers to reset values; the divider is held reset via div_rst.
- No op is lost: the op stays on the inputs while stall=1, and the execute stage holds it.

Decomposition:
- Shared package hilo_pkg holds:
  - Opcode constants: OP_NONE=0, OP_DIV=1, OP_MTHI=2, OP_MTLO=3, OP_MFHI=4, OP_MFLO=5; values 6-7 are treated as NONE.
  - Localparams for state encoding: IDLE=0, WAIT=1.
- One natural sub-module, hilo_timeout_cnt: counter with clear, enable and terminal-count output.
- Divider instantiation lives in the parent datapath, not inside this block.

Test Plan:
- DIV rs=100, rt=7 with a divider model (div_end after 33 cycles) -> busy for the wait; div_start high exactly 1 cycle; then hi=2, lo=14; busy=0.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV rs=5, rt=0 -> dz_err=1 for one cycle; div_start never asserts; hi/lo keep prior values (preload MTHI 0xAAAA, MTLO 0x5555).
- MFLO issued 2 cycles after a DIV 100/7 -> stall=1 until the cycle after div_end; then rd_data=14 with stall=0.
- DIV 9/3 with div_end tied 0 -> to_err and div_rst pulse at cycle TIMEOUT after launch; state IDLE; hi/lo unchanged; a following MTHI 0x1234 gives hi=0x1234.
- rst=0 at WAIT cycle 10 of a DIV -> hi=lo=0, busy=0 next cycle; a later div_end pulse is ignored.
